bank_lfb_ctrl: RTL and testbench

Linefill-buffer controller for one cache bank. It tracks each outstanding linefill by ID, collects the 128-bit BIU read beats into a 64-entry × 256-bit line store, and pulses a completion (`rvalid`/`rid`) toward the bank issue queue once a line is whole. It serves the issue queue's read port by `raddr` and frees each entry when the SRAM controller releases it.

---
 rtl/bank_lfb_ctrl_pkg.sv | 16 +
 rtl/bank_lfb_ctrl_if.sv | 44 ++++
 rtl/bank_lfb_store.sv | 27 ++
 rtl/bank_lfb_ctrl.sv | 129 ++++++++++++
 tb/tb_bank_lfb_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/bank_lfb_ctrl_pkg.sv
// Shared types and sizing constants for the bank linefill-buffer controller.
package bank_pkg;

  localparam int LFB_ID_WIDTH   = 6;
  localparam int LFB_BEAT_WIDTH = 128;

  typedef logic [LFB_ID_WIDTH-1:0] lfb_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HALF = 2'd2,
    DONE = 2'd3
  } lfb_state_e;

endpackage

// File: rtl/bank_lfb_ctrl_if.sv
// Bus bundle between the linefill-buffer controller and its neighbours (miss path,
// BIU read channel, issue queue, SRAM release), plus debug visibility of entry state.
interface bank_lfb_ctrl_if #(
  parameter int ID_WIDTH   = bank_pkg::LFB_ID_WIDTH,
  parameter int BEAT_WIDTH = bank_pkg::LFB_BEAT_WIDTH
);
  import bank_pkg::*;

  // Valid/ready: a transfer happens on a rising clock edge where both valid and ready
  // are high; valid may not depend on ready, and payload is only meaningful with valid.
  logic                    alloc_valid_i;
  logic [ID_WIDTH-1:0]     alloc_id_i;
  logic                    alloc_ready_o;
  logic                    biu_rvalid_i;
  logic                    biu_rready_o;
  logic [ID_WIDTH-1:0]     biu_rid_i;
  logic [BEAT_WIDTH-1:0]   biu_rdata_i;
  logic                    biu_rlast_i;
  logic                    lfb_isu_rvalid_o;
  logic [ID_WIDTH-1:0]     lfb_isu_rid_o;
  logic [ID_WIDTH-1:0]     iq_lfb_raddr_i;
  logic [2*BEAT_WIDTH-1:0] lfb_iq_rdata_o;
  logic                    release_valid_i;
  logic [ID_WIDTH-1:0]     release_id_i;
  logic [ID_WIDTH:0]       pend_cnt_o;
  logic                    err_o;
  lfb_state_e              dbg_state_o;
  logic                    dbg_beat_idx_o;

  modport slave (
    input  alloc_valid_i, alloc_id_i, biu_rvalid_i, biu_rid_i, biu_rdata_i, biu_rlast_i,
           iq_lfb_raddr_i, release_valid_i, release_id_i,
    output alloc_ready_o, biu_rready_o, lfb_isu_rvalid_o, lfb_isu_rid_o, lfb_iq_rdata_o,
           pend_cnt_o, err_o, dbg_state_o, dbg_beat_idx_o
  );

  modport master (
    output alloc_valid_i, alloc_id_i, biu_rvalid_i, biu_rid_i, biu_rdata_i, biu_rlast_i,
           iq_lfb_raddr_i, release_valid_i, release_id_i,
    input  alloc_ready_o, biu_rready_o, lfb_isu_rvalid_o, lfb_isu_rid_o, lfb_iq_rdata_o,
           pend_cnt_o, err_o, dbg_state_o, dbg_beat_idx_o
  );

endinterface

// File: rtl/bank_lfb_store.sv
// Line store: one write port with per-half enables, one asynchronous read port.
// Contents are deliberately not reset.
module bank_lfb_store #(
  parameter int ID_WIDTH   = 6,
  parameter int BEAT_WIDTH = 128
) (
  input  logic                    i_clk,
  input  logic                    i_we_lo,
  input  logic                    i_we_hi,
  input  logic [ID_WIDTH-1:0]     i_waddr,
  input  logic [BEAT_WIDTH-1:0]   i_wdata,
  input  logic [ID_WIDTH-1:0]     i_raddr,
  output logic [2*BEAT_WIDTH-1:0] o_rdata
);

  localparam int ENTRIES = 2 ** ID_WIDTH;

  logic [2*BEAT_WIDTH-1:0] r_mem [ENTRIES];

  always_ff @(posedge i_clk) begin
    if (i_we_lo) r_mem[i_waddr][BEAT_WIDTH-1:0]            <= i_wdata;
    if (i_we_hi) r_mem[i_waddr][2*BEAT_WIDTH-1:BEAT_WIDTH] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bank_lfb_ctrl.sv
// Linefill-buffer controller: per-ID entry FSMs, beat collection into the line store,
// completion pulse, pending counter and sticky protocol-error flag.
module bank_lfb_ctrl
  import bank_pkg::*;
#(
  parameter int ID_WIDTH   = LFB_ID_WIDTH,
  parameter int BEAT_WIDTH = LFB_BEAT_WIDTH
) (
  input logic              clk_i,
  input logic              rst_n_i,
  bank_lfb_ctrl_if.slave   bus
);

  localparam int ENTRIES = 2 ** ID_WIDTH;
  localparam logic [ID_WIDTH:0] CNT_ONE = (ID_WIDTH+1)'(1);

  lfb_state_e            r_state     [ENTRIES];
  lfb_state_e            w_state_nxt [ENTRIES];
  logic [ENTRIES-1:0]    r_beat_idx;
  logic [ENTRIES-1:0]    w_beat_idx_nxt;
  logic                  r_rready;
  logic                  r_cmp_valid;
  logic [ID_WIDTH-1:0]   r_cmp_id;
  logic [ID_WIDTH:0]     r_pend_cnt;
  logic                  r_err;

  logic                  w_alloc_fire;
  logic                  w_beat_fire;
  logic                  w_rel_fire;
  logic                  w_err_set;
  logic                  w_we_lo;
  logic                  w_we_hi;
  logic                  w_cmp_nxt;
  logic [ID_WIDTH:0]     w_pend_cnt_nxt;

  // Alloc, beat and release each require a different current state, so at most one
  // of them can move a given entry in a cycle and they can be applied independently.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_idx_nxt = r_beat_idx;
    w_err_set      = 1'b0;
    w_we_lo        = 1'b0;
    w_we_hi        = 1'b0;
    w_cmp_nxt      = 1'b0;
    w_alloc_fire   = bus.alloc_valid_i && (r_state[bus.alloc_id_i] == IDLE);
    w_beat_fire    = bus.biu_rvalid_i && r_rready;
    w_rel_fire     = bus.release_valid_i && (r_state[bus.release_id_i] == DONE);

    if (w_alloc_fire) begin
      w_state_nxt[bus.alloc_id_i]    = PEND;
      w_beat_idx_nxt[bus.alloc_id_i] = 1'b0;
    end

    if (w_beat_fire) begin
      case (r_state[bus.biu_rid_i])
        PEND: begin
          w_we_lo                       = 1'b1;
          w_state_nxt[bus.biu_rid_i]    = HALF;
          w_beat_idx_nxt[bus.biu_rid_i] = 1'b1;
          w_err_set                     = bus.biu_rlast_i;
        end
        HALF: begin
          w_we_hi                    = 1'b1;
          w_state_nxt[bus.biu_rid_i] = DONE;
          w_cmp_nxt                  = 1'b1;
          w_err_set                  = !bus.biu_rlast_i;
        end
        default: w_err_set = 1'b1;
      endcase
    end

    if (bus.release_valid_i) begin
      if (w_rel_fire) w_state_nxt[bus.release_id_i] = IDLE;
      else            w_err_set = 1'b1;
    end
  end

  always_comb begin
    w_pend_cnt_nxt = r_pend_cnt;
    case ({w_alloc_fire, w_rel_fire})
      2'b10:   w_pend_cnt_nxt = r_pend_cnt + CNT_ONE;
      2'b01:   w_pend_cnt_nxt = r_pend_cnt - CNT_ONE;
      default: w_pend_cnt_nxt = r_pend_cnt;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRIES; i++) r_state[i] <= IDLE;
      r_beat_idx  <= '0;
      r_rready    <= 1'b0;
      r_cmp_valid <= 1'b0;
      r_cmp_id    <= '0;
      r_pend_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat_idx  <= w_beat_idx_nxt;
      r_rready    <= 1'b1;
      r_cmp_valid <= w_cmp_nxt;
      if (w_cmp_nxt) r_cmp_id <= bus.biu_rid_i;
      r_pend_cnt  <= w_pend_cnt_nxt;
      r_err       <= r_err | w_err_set;
    end
  end

  bank_lfb_store #(
    .ID_WIDTH   (ID_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_store (
    .i_clk   (clk_i),
    .i_we_lo (w_we_lo),
    .i_we_hi (w_we_hi),
    .i_waddr (bus.biu_rid_i),
    .i_wdata (bus.biu_rdata_i),
    .i_raddr (bus.iq_lfb_raddr_i),
    .o_rdata (bus.lfb_iq_rdata_o)
  );

  assign bus.alloc_ready_o    = (r_state[bus.alloc_id_i] == IDLE);
  assign bus.biu_rready_o     = r_rready;
  assign bus.lfb_isu_rvalid_o = r_cmp_valid;
  assign bus.lfb_isu_rid_o    = r_cmp_id;
  assign bus.pend_cnt_o       = r_pend_cnt;
  assign bus.err_o            = r_err;
  assign bus.dbg_state_o      = r_state[bus.iq_lfb_raddr_i];
  assign bus.dbg_beat_idx_o   = r_beat_idx[bus.iq_lfb_raddr_i];

endmodule

// File: tb/tb_bank_lfb_ctrl.sv
// Bench for bank_lfb_ctrl: table of per-cycle vectors, hand-written corner sequences,
// and a completion scoreboard checking pulse ID and one-cycle latency.
module tb_bank_lfb_ctrl;
  import bank_pkg::*;

  typedef struct {
    logic         av;
    lfb_id_t      aid;
    logic         bv;
    lfb_id_t      bid;
    logic [127:0] bd;
    logic         bl;
    logic         cmp;
    logic         rv;
    lfb_id_t      rl;
    lfb_id_t      ra;
    logic         crd;
    logic [255:0] erd;
    logic         ardy;
    logic [6:0]   cnt;
    logic         err;
    lfb_state_e   st;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [37:0] exp_q[$];
  logic [37:0] sb_e;
  vec_t vt [28];
  logic [127:0] d0, d1, d2, d3;

  bank_lfb_ctrl_if #(.ID_WIDTH(6), .BEAT_WIDTH(128)) bus ();

  bank_lfb_ctrl #(.ID_WIDTH(6), .BEAT_WIDTH(128)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] B(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [255:0] L(input logic [7:0] hi, input logic [7:0] lo);
    return {B(hi), B(lo)};
  endfunction

  function automatic vec_t mk(input logic av, input lfb_id_t aid, input logic bv,
                              input lfb_id_t bid, input logic [127:0] bd, input logic bl,
                              input logic cmp, input logic rv, input lfb_id_t rl,
                              input lfb_id_t ra, input logic crd, input logic [255:0] erd,
                              input logic ardy, input logic [6:0] cnt, input logic err,
                              input lfb_state_e st);
    vec_t v;
    v.av = av; v.aid = aid; v.bv = bv; v.bid = bid; v.bd = bd; v.bl = bl; v.cmp = cmp;
    v.rv = rv; v.rl = rl; v.ra = ra; v.crd = crd; v.erd = erd; v.ardy = ardy;
    v.cnt = cnt; v.err = err; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic idle_in(input lfb_id_t id);
    bus.alloc_valid_i   = 1'b0;
    bus.alloc_id_i      = id;
    bus.biu_rvalid_i    = 1'b0;
    bus.biu_rid_i       = '0;
    bus.biu_rdata_i     = '0;
    bus.biu_rlast_i     = 1'b0;
    bus.release_valid_i = 1'b0;
    bus.release_id_i    = '0;
    bus.iq_lfb_raddr_i  = id;
  endtask

  // Drive one cycle of inputs; check values that reflect state before this cycle's edge.
  task automatic apply_row(input vec_t v, input string tag);
    @(negedge clk);
    bus.alloc_valid_i   = v.av;
    bus.alloc_id_i      = v.aid;
    bus.biu_rvalid_i    = v.bv;
    bus.biu_rid_i       = v.bid;
    bus.biu_rdata_i     = v.bd;
    bus.biu_rlast_i     = v.bl;
    bus.release_valid_i = v.rv;
    bus.release_id_i    = v.rl;
    bus.iq_lfb_raddr_i  = v.ra;
    if (v.cmp) exp_q.push_back({32'(cyc + 1), v.bid});
    #1;
    chk({tag, "_ardy"}, bus.alloc_ready_o, v.ardy);
    chk({tag, "_cnt"}, bus.pend_cnt_o, v.cnt);
    chk({tag, "_err"}, bus.err_o, v.err);
    chk({tag, "_st"}, bus.dbg_state_o, v.st);
    if (v.crd) chk({tag, "_rd"}, bus.lfb_iq_rdata_o, v.erd);
  endtask

  task automatic reset_seq(input lfb_id_t id, input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    idle_in(id);
    #1;
    chk({tag, "_rvalid"}, bus.lfb_isu_rvalid_o, 1'b0);
    chk({tag, "_rid"}, bus.lfb_isu_rid_o, '0);
    chk({tag, "_cnt"}, bus.pend_cnt_o, '0);
    chk({tag, "_err"}, bus.err_o, 1'b0);
    chk({tag, "_rready"}, bus.biu_rready_o, 1'b0);
    chk({tag, "_ardy"}, bus.alloc_ready_o, 1'b1);
    chk({tag, "_st"}, bus.dbg_state_o, IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({tag, "_rready_rel"}, bus.biu_rready_o, 1'b0);
    @(negedge clk);
    #1;
    chk({tag, "_rready_up"}, bus.biu_rready_o, 1'b1);
  endtask

  // Completion scoreboard: each expected pulse carries the cycle it is due in.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #3;
      if (exp_q.size() != 0 && exp_q[0][37:6] == 32'(cyc)) begin
        sb_e = exp_q.pop_front();
        chk("cmp_valid", bus.lfb_isu_rvalid_o, 1'b1);
        chk("cmp_rid", bus.lfb_isu_rid_o, sb_e[5:0]);
      end else begin
        chk("no_cmp", bus.lfb_isu_rvalid_o, 1'b0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle_in('0);

    vt[0]  = mk(1,5, 0,0,B(8'h00),0,0, 0,0, 5, 0,'0,         1,0,0,IDLE);
    vt[1]  = mk(0,5, 1,5,B(8'hAA),0,0, 0,0, 5, 0,'0,         0,1,0,PEND);
    vt[2]  = mk(0,5, 1,5,B(8'hBB),1,1, 0,0, 5, 0,'0,         0,1,0,HALF);
    vt[3]  = mk(0,5, 0,0,B(8'h00),0,0, 0,0, 5, 1,L(8'hBB,8'hAA), 0,1,0,DONE);
    vt[4]  = mk(0,5, 0,0,B(8'h00),0,0, 1,5, 5, 1,L(8'hBB,8'hAA), 0,1,0,DONE);
    vt[5]  = mk(0,5, 0,0,B(8'h00),0,0, 0,0, 5, 1,L(8'hBB,8'hAA), 1,0,0,IDLE);
    vt[6]  = mk(1,1, 0,0,B(8'h00),0,0, 0,0, 1, 0,'0,         1,0,0,IDLE);
    vt[7]  = mk(1,2, 0,0,B(8'h00),0,0, 0,0, 2, 0,'0,         1,1,0,IDLE);
    vt[8]  = mk(0,1, 1,1,B(8'h11),0,0, 0,0, 1, 0,'0,         0,2,0,PEND);
    vt[9]  = mk(0,2, 1,2,B(8'h21),0,0, 0,0, 2, 0,'0,         0,2,0,PEND);
    vt[10] = mk(0,2, 1,2,B(8'h22),1,1, 0,0, 2, 0,'0,         0,2,0,HALF);
    vt[11] = mk(0,1, 1,1,B(8'h12),1,1, 0,0, 1, 0,'0,         0,2,0,HALF);
    vt[12] = mk(0,2, 0,0,B(8'h00),0,0, 0,0, 2, 1,L(8'h22,8'h21), 0,2,0,DONE);
    vt[13] = mk(0,1, 0,0,B(8'h00),0,0, 1,1, 1, 1,L(8'h12,8'h11), 0,2,0,DONE);
    vt[14] = mk(0,1, 0,0,B(8'h00),0,0, 1,2, 1, 1,L(8'h12,8'h11), 1,1,0,IDLE);
    vt[15] = mk(0,2, 0,0,B(8'h00),0,0, 0,0, 2, 1,L(8'h22,8'h21), 1,0,0,IDLE);
    vt[16] = mk(1,7, 0,0,B(8'h00),0,0, 0,0, 7, 0,'0,         1,0,0,IDLE);
    vt[17] = mk(0,7, 1,7,B(8'h71),0,0, 0,0, 7, 0,'0,         0,1,0,PEND);
    vt[18] = mk(0,7, 1,7,B(8'h72),1,1, 0,0, 7, 0,'0,         0,1,0,HALF);
    vt[19] = mk(0,7, 0,0,B(8'h00),0,0, 1,7, 7, 1,L(8'h72,8'h71), 0,1,0,DONE);
    vt[20] = mk(1,3, 0,0,B(8'h00),0,0, 0,0, 7, 1,L(8'h72,8'h71), 1,0,0,IDLE);
    vt[21] = mk(0,7, 1,7,B(8'h77),0,0, 0,0, 7, 1,L(8'h72,8'h71), 1,1,0,IDLE);
    vt[22] = mk(0,3, 0,0,B(8'h00),0,0, 1,3, 7, 1,L(8'h72,8'h71), 0,1,1,IDLE);
    vt[23] = mk(1,6, 0,0,B(8'h00),0,0, 0,0, 3, 0,'0,         1,1,1,PEND);
    vt[24] = mk(0,6, 1,6,B(8'h61),1,0, 0,0, 6, 0,'0,         0,2,1,PEND);
    vt[25] = mk(0,6, 1,6,B(8'h62),1,1, 0,0, 6, 0,'0,         0,2,1,HALF);
    vt[26] = mk(0,6, 0,0,B(8'h00),0,0, 0,0, 6, 1,L(8'h62,8'h61), 0,2,1,DONE);
    vt[27] = mk(0,3, 0,0,B(8'h00),0,0, 0,0, 3, 0,'0,         0,2,1,PEND);

    reset_seq(0, "por");
    for (int i = 0; i < 28; i++) apply_row(vt[i], $sformatf("t%0d", i));

    // rlast high on a first beat, then rlast low on a second beat
    d0 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    d3 = {$urandom, $urandom, $urandom, $urandom};
    reset_seq(10, "rst_a");
    apply_row(mk(1,10, 0,0,'0,0,0, 0,0, 10, 0,'0, 1,0,0,IDLE), "rl1_alloc");
    apply_row(mk(0,10, 1,10,d0,1,0, 0,0, 10, 0,'0, 0,1,0,PEND), "rl1_b0");
    apply_row(mk(0,10, 1,10,d1,1,1, 0,0, 10, 0,'0, 0,1,1,HALF), "rl1_b1");
    apply_row(mk(0,10, 0,0,'0,0,0, 0,0, 10, 1,{d1,d0}, 0,1,1,DONE), "rl1_done");
    reset_seq(11, "rst_b");
    apply_row(mk(1,11, 0,0,'0,0,0, 0,0, 11, 0,'0, 1,0,0,IDLE), "rl0_alloc");
    apply_row(mk(0,11, 1,11,d2,0,0, 0,0, 11, 0,'0, 0,1,0,PEND), "rl0_b0");
    apply_row(mk(0,11, 1,11,d3,0,1, 0,0, 11, 0,'0, 0,1,0,HALF), "rl0_b1");
    apply_row(mk(0,11, 0,0,'0,0,0, 0,0, 11, 1,{d3,d2}, 0,1,1,DONE), "rl0_done");

    // Full occupancy, different-ID alloc/release, same-ID race
    reset_seq(0, "rst_c");
    for (int i = 0; i < 64; i++)
      apply_row(mk(1,i[5:0], 0,0,'0,0,0, 0,0, i[5:0], 0,'0, 1,i[6:0],0,IDLE), "occ");
    apply_row(mk(1,33, 0,0,'0,0,0, 0,0, 33, 0,'0, 0,64,0,PEND), "occ_full");
    apply_row(mk(0,33, 0,0,'0,0,0, 0,0, 33, 0,'0, 0,64,0,PEND), "occ_hold");
    apply_row(mk(0,9,  1,9,d0,0,0,  0,0, 9,  0,'0, 0,64,0,PEND), "f9_b0");
    apply_row(mk(0,9,  1,9,d1,1,1,  0,0, 9,  0,'0, 0,64,0,HALF), "f9_b1");
    apply_row(mk(0,10, 1,10,d2,0,0, 0,0, 10, 0,'0, 0,64,0,PEND), "f10_b0");
    apply_row(mk(0,10, 1,10,d3,1,1, 0,0, 10, 0,'0, 0,64,0,HALF), "f10_b1");
    apply_row(mk(0,10, 0,0,'0,0,0,  1,10, 9, 1,{d1,d0}, 0,64,0,DONE), "rel10");
    apply_row(mk(1,10, 0,0,'0,0,0,  1,9,  9, 1,{d1,d0}, 1,63,0,DONE), "mix");
    apply_row(mk(0,10, 0,0,'0,0,0,  0,0,  9, 0,'0, 0,63,0,IDLE), "mix_after");
    d0 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom_range(255, 0), 96'h0, $urandom};
    apply_row(mk(1,9, 0,0,'0,0,0,  0,0, 9, 0,'0, 1,63,0,IDLE), "r9_alloc");
    apply_row(mk(0,9, 1,9,d0,0,0,  0,0, 9, 0,'0, 0,64,0,PEND), "r9_b0");
    apply_row(mk(0,9, 1,9,d1,1,1,  0,0, 9, 0,'0, 0,64,0,HALF), "r9_b1");
    apply_row(mk(1,9, 0,0,'0,0,0,  1,9, 9, 1,{d1,d0}, 0,64,0,DONE), "race");
    apply_row(mk(1,9, 0,0,'0,0,0,  0,0, 9, 0,'0, 1,63,0,IDLE), "race_retry");
    apply_row(mk(0,9, 0,0,'0,0,0,  0,0, 9, 0,'0, 0,64,0,PEND), "race_after");

    // Reset in the middle of a fill, then a clean refill of the same ID
    reset_seq(4, "rst_d");
    apply_row(mk(1,4, 0,0,'0,0,0, 0,0, 4, 0,'0, 1,0,0,IDLE), "mid_alloc");
    apply_row(mk(0,4, 1,4,d0,0,0, 0,0, 4, 0,'0, 0,1,0,PEND), "mid_b0");
    reset_seq(4, "rst_mid");
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    apply_row(mk(1,4, 0,0,'0,0,0, 0,0, 4, 0,'0, 1,0,0,IDLE), "re_alloc");
    apply_row(mk(0,4, 1,4,d1,0,0, 0,0, 4, 0,'0, 0,1,0,PEND), "re_b0");
    apply_row(mk(0,4, 1,4,d2,1,1, 0,0, 4, 0,'0, 0,1,0,HALF), "re_b1");
    apply_row(mk(0,4, 0,0,'0,0,0, 0,0, 4, 1,{d2,d1}, 0,1,0,DONE), "re_done");
    apply_row(mk(0,4, 0,0,'0,0,0, 1,4, 4, 1,{d2,d1}, 0,1,0,DONE), "re_rel");
    apply_row(mk(0,4, 0,0,'0,0,0, 0,0, 4, 0,'0, 1,0,0,IDLE), "re_free");

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
